// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. The head entry drives the register-file write port and the
// hazard/forwarding taps. in_ready_o is registered, so there is no
// combinational ready path back into MEM.
module mem_wb_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_data_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_we_o,
    output logic              fwd_we_o
);

    // Head (h_*) and skid (s_*) entries plus the registered ready flag
    logic              h_valid, s_valid, ready_q;
    logic [CTRL_W-1:0] h_ctrl, s_ctrl;
    logic [DATA_W-1:0] h_rdata, s_rdata, h_alu, s_alu;
    logic [REG_W-1:0]  h_rd, s_rd;

    logic              h_valid_n, s_valid_n, ready_n;
    logic [CTRL_W-1:0] h_ctrl_n, s_ctrl_n;
    logic [DATA_W-1:0] h_rdata_n, s_rdata_n, h_alu_n, s_alu_n;
    logic [REG_W-1:0]  h_rd_n, s_rd_n;

    logic accept, pop;

    assign accept = in_valid_i & ready_q & ~flush_i;
    assign pop    = h_valid & out_ready_i;

    // Next-state for both entries; reset and flush take priority over data moves
    always_comb begin
        h_valid_n = h_valid;
        h_ctrl_n  = h_ctrl;
        h_rdata_n = h_rdata;
        h_alu_n   = h_alu;
        h_rd_n    = h_rd;
        s_valid_n = s_valid;
        s_ctrl_n  = s_ctrl;
        s_rdata_n = s_rdata;
        s_alu_n   = s_alu;
        s_rd_n    = s_rd;

        if (rst_i) begin
            h_valid_n = 1'b0;
            h_ctrl_n  = '0;
            h_rdata_n = '0;
            h_alu_n   = '0;
            h_rd_n    = '0;
            s_valid_n = 1'b0;
            s_ctrl_n  = '0;
            s_rdata_n = '0;
            s_alu_n   = '0;
            s_rd_n    = '0;
        end else if (flush_i) begin
            h_valid_n = 1'b0;
            s_valid_n = 1'b0;
        end else if (s_valid) begin
            // Full: only a pop can happen, skid entry advances into the head
            if (pop) begin
                h_valid_n = 1'b1;
                h_ctrl_n  = s_ctrl;
                h_rdata_n = s_rdata;
                h_alu_n   = s_alu;
                h_rd_n    = s_rd;
                s_valid_n = 1'b0;
            end
        end else if (h_valid) begin
            if (accept && pop) begin
                h_ctrl_n  = ctrl_i;
                h_rdata_n = read_data_i;
                h_alu_n   = alu_data_i;
                h_rd_n    = rd_i;
            end else if (accept) begin
                s_valid_n = 1'b1;
                s_ctrl_n  = ctrl_i;
                s_rdata_n = read_data_i;
                s_alu_n   = alu_data_i;
                s_rd_n    = rd_i;
            end else if (pop) begin
                h_valid_n = 1'b0;
            end
        end else if (accept) begin
            h_valid_n = 1'b1;
            h_ctrl_n  = ctrl_i;
            h_rdata_n = read_data_i;
            h_alu_n   = alu_data_i;
            h_rd_n    = rd_i;
        end

        ready_n = ~rst_i & ~s_valid_n;
    end

    // State registers; synchronous reset is folded into the next-state logic
    always_ff @(posedge clk_i) begin
        h_valid <= h_valid_n;
        h_ctrl  <= h_ctrl_n;
        h_rdata <= h_rdata_n;
        h_alu   <= h_alu_n;
        h_rd    <= h_rd_n;
        s_valid <= s_valid_n;
        s_ctrl  <= s_ctrl_n;
        s_rdata <= s_rdata_n;
        s_alu   <= s_alu_n;
        s_rd    <= s_rd_n;
        ready_q <= ready_n;
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = h_valid;
    assign ctrl_o      = h_ctrl;
    assign read_data_o = h_rdata;
    assign alu_data_o  = h_alu;
    assign rd_o        = h_rd;

    // Write-back taps depend only on the head entry and out_ready_i
    assign wb_data_o = h_ctrl[1] ? h_rdata : h_alu;
    assign fwd_we_o  = h_valid & h_ctrl[0];
    assign wb_we_o   = h_valid & h_ctrl[0] & out_ready_i & (h_rd != '0);

endmodule
